// File: rtl/fifo_ram_ctrl.sv
// Sequencer that turns a dual-port RAM into a synchronous FIFO: pointers,
// occupancy, level flags, read-valid strobe and sticky error flags.
module fifo_ram_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_re_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              rd_valid,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C   = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C  = CNT_W'(AEMPTY_TH);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              rd_valid_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              push_acc_s;
    logic              pop_acc_s;
    logic              ovf_set_s;
    logic              udf_set_s;

    assign full         = (count_r == DEPTH_C);
    assign empty        = (count_r == {CNT_W{1'b0}});
    assign almost_full  = (count_r >= AFULL_C);
    assign almost_empty = (count_r <= AEMPTY_C);

    // Acceptance is gated by reset so the RAM enables read 0 while reset is held.
    assign pop_acc_s  = wrst_n & pop & ~empty & ~flush;
    assign push_acc_s = wrst_n & push & ~flush & (~full | pop_acc_s);
    assign ovf_set_s  = push & ~flush & full & ~pop_acc_s;
    assign udf_set_s  = pop & ~flush & empty;

    assign ram_we_a   = push_acc_s;
    assign ram_addr_a = wr_ptr_r;
    assign ram_re_b   = pop_acc_s;
    assign ram_addr_b = rd_ptr_r;
    assign count      = count_r;
    assign rd_valid   = rd_valid_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;

    // Pointer, occupancy and read-valid state; flush clears it synchronously.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
            rd_valid_r <= pop_acc_s;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins over clr_err.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (udf_set_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed bench for fifo_ram_ctrl: a push/pop-total model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fifo_ram_ctrl;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              wclk = 1'b0;
    logic              wrst_n = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              flush = 1'b0;
    logic              clr_err = 1'b0;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_a;
    logic              ram_re_b;
    logic [ADDR_W-1:0] ram_addr_b;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              rd_valid;
    logic              overflow;
    logic              underflow;

    int n_pass = 0;
    int n_total = 0;

    fifo_ram_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .push(push), .pop(pop), .flush(flush),
        .clr_err(clr_err), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
        .ram_re_b(ram_re_b), .ram_addr_b(ram_addr_b), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .rd_valid(rd_valid), .overflow(overflow), .underflow(underflow)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: totals of accepted pushes and pops since the last clear.
    int m_pushes = 0;
    int m_pops = 0;
    bit m_rdv = 1'b0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;
    int m_cnt;
    bit e_push;
    bit e_pop;

    always_comb begin
        m_cnt  = m_pushes - m_pops;
        e_pop  = wrst_n && pop && !flush && (m_cnt > 0);
        e_push = wrst_n && push && !flush && ((m_cnt < DEPTH) || e_pop);
    end

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_pushes <= 0;
            m_pops   <= 0;
            m_rdv    <= 1'b0;
            m_ovf    <= 1'b0;
            m_udf    <= 1'b0;
        end else begin
            if (flush) begin
                m_pushes <= 0;
                m_pops   <= 0;
                m_rdv    <= 1'b0;
            end else begin
                m_pushes <= m_pushes + (e_push ? 1 : 0);
                m_pops   <= m_pops + (e_pop ? 1 : 0);
                m_rdv    <= e_pop;
            end
            m_ovf <= (push && !flush && m_cnt == DEPTH && !e_pop) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            m_udf <= (pop && !flush && m_cnt == 0) ? 1'b1 : (clr_err ? 1'b0 : m_udf);
        end
    end

    always @(negedge wclk) begin
        chk("m_we",     int'(ram_we_a),     int'(e_push));
        chk("m_re",     int'(ram_re_b),     int'(e_pop));
        chk("m_addr_a", int'(ram_addr_a),   m_pushes % DEPTH);
        chk("m_addr_b", int'(ram_addr_b),   m_pops % DEPTH);
        chk("m_count",  int'(count),        m_cnt);
        chk("m_full",   int'(full),         int'(m_cnt == DEPTH));
        chk("m_empty",  int'(empty),        int'(m_cnt == 0));
        chk("m_afull",  int'(almost_full),  int'(m_cnt >= 6));
        chk("m_aempty", int'(almost_empty), int'(m_cnt <= 2));
        chk("m_rdv",    int'(rd_valid),     int'(m_rdv));
        chk("m_ovf",    int'(overflow),     int'(m_ovf));
        chk("m_udf",    int'(underflow),    int'(m_udf));
    end

    // Apply inputs for one cycle; returns at that cycle's falling edge.
    task automatic cyc(input bit p, input bit q, input bit f, input bit c);
        @(posedge wclk);
        #1;
        push = p; pop = q; flush = f; clr_err = c;
        @(negedge wclk);
    endtask

    initial begin
        repeat (2) @(negedge wclk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_aempty", int'(almost_empty), 1);
        chk("rst_count", int'(count), 0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;

        // Fill to full.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("fill_we", int'(ram_we_a), 1);
            chk("fill_addr", int'(ram_addr_a), i);
            chk("fill_count", int'(count), i);
            chk("fill_afull", int'(almost_full), int'(i >= 6));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_count", int'(count), 8);
        chk("full_flag", int'(full), 1);

        // Push into full, then clear the sticky overflow.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_we", int'(ram_we_a), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_clr", int'(overflow), 0);

        // Simultaneous push/pop while full.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk("pp_we", int'(ram_we_a), 1);
            chk("pp_re", int'(ram_re_b), 1);
            chk("pp_addr_a", int'(ram_addr_a), i);
            chk("pp_addr_b", int'(ram_addr_b), i);
            chk("pp_rdv", int'(rd_valid), int'(i > 0));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pp_rdv_last", int'(rd_valid), 1);
        chk("pp_count", int'(count), 8);
        chk("pp_ovf", int'(overflow), 0);

        // Drain, then one pop too many.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            chk("drain_re", int'(ram_re_b), 1);
            chk("drain_addr", int'(ram_addr_b), (3 + i) % 8);
            chk("drain_rdv", int'(rd_valid), int'(i > 0));
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("udf_empty", int'(empty), 1);
        chk("udf_re", int'(ram_re_b), 0);
        chk("udf_rdv_prev", int'(rd_valid), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("udf_set", int'(underflow), 1);
        chk("udf_rdv", int'(rd_valid), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("udf_clr", int'(underflow), 0);

        // Wrap-around after a flush.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("wrap_addr", int'(ram_addr_a), (5 + i) % 8);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_count", int'(count), 6);
        chk("wrap_afull", int'(almost_full), 1);

        // Flush beats push and pop.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_cnt_pre", int'(count), 4);
        chk("flush_we", int'(ram_we_a), 0);
        chk("flush_re", int'(ram_re_b), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_addr_a", int'(ram_addr_a), 0);
        chk("flush_addr_b", int'(ram_addr_b), 0);

        // Push and pop while empty: only the push goes through.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("epp_we", int'(ram_we_a), 1);
        chk("epp_re", int'(ram_re_b), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("epp_count", int'(count), 1);
        chk("epp_udf", int'(underflow), 1);
        chk("epp_rdv", int'(rd_valid), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("udf_cleared", int'(underflow), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("udf_set_wins", int'(underflow), 1);

        // Asynchronous reset in the middle of a burst.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("burst_rdv", int'(rd_valid), 1);
        chk("burst_count", int'(count), 2);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_rdv", int'(rd_valid), 0);
        chk("arst_we", int'(ram_we_a), 0);
        chk("arst_re", int'(ram_re_b), 0);
        chk("arst_addr_a", int'(ram_addr_a), 0);
        chk("arst_udf", int'(underflow), 0);
        @(posedge wclk);
        #1;
        push = 1'b0;
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_we", int'(ram_we_a), 1);
        chk("post_addr", int'(ram_addr_a), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_count", int'(count), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
